// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state, instruction-class and datapath select encodings for mc_ctrl_fsm
package mc_ctrl_pkg;

  // One state per datapath cycle; INIT must stay at zero so state_o reads 0 in reset.
  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_WB_R   = 4'd4,
    ST_EXEC_I = 4'd5,
    ST_WB_I   = 4'd6,
    ST_MADDR  = 4'd7,
    ST_MRD    = 4'd8,
    ST_MWB    = 4'd9,
    ST_MWR    = 4'd10,
    ST_BR     = 4'd11,
    ST_JMP    = 4'd12
  } state_t;

  // Instruction classes the FSM distinguishes; everything else is CL_ILLEGAL.
  typedef enum logic [3:0] {
    CL_ADDU,
    CL_SUBU,
    CL_ORI,
    CL_LUI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_JAL,
    CL_JR,
    CL_ILLEGAL
  } iclass_t;

  // IR[31:26] opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // IR[5:0] function codes for R-type
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  // PC source
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_GPR    = 2'b11;

  // Destination register
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // Register write data
  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;
  localparam logic [1:0] WD_LUI    = 2'b11;

  // ALU operand A / B
  localparam logic       A_PC   = 1'b0;
  localparam logic       A_GPR  = 1'b1;
  localparam logic [1:0] B_GPR  = 2'b00;
  localparam logic [1:0] B_FOUR = 2'b01;
  localparam logic [1:0] B_SEXT = 2'b10;
  localparam logic [1:0] B_ZEXT = 2'b11;

  // ALU operation
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// rtl/mc_ctrl_fsm_decode.sv - combinational opcode/funct to instruction-class decoder
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       illegal
);

  // Map IR fields to a class; unknown encodings fall through to CL_ILLEGAL.
  always_comb begin
    iclass = CL_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = CL_ADDU;
          FN_SUBU: iclass = CL_SUBU;
          FN_JR:   iclass = CL_JR;
          default: iclass = CL_ILLEGAL;
        endcase
      end
      OP_ORI:  iclass = CL_ORI;
      OP_LUI:  iclass = CL_LUI;
      OP_LW:   iclass = CL_LW;
      OP_SW:   iclass = CL_SW;
      OP_BEQ:  iclass = CL_BEQ;
      OP_J:    iclass = CL_J;
      OP_JAL:  iclass = CL_JAL;
      default: iclass = CL_ILLEGAL;
    endcase
  end

  assign illegal = (iclass == CL_ILLEGAL);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS control FSM driving the shared single-ALU datapath
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_sel,
  output logic            reg_write,
  output logic [1:0]      reg_dst_sel,
  output logic [1:0]      wd_sel,
  output logic            alu_a_sel,
  output logic [1:0]      alu_b_sel,
  output logic [1:0]      alu_ctrl,
  output logic            illegal,
  output logic [ST_W-1:0] state_o
);

  state_t  state;
  state_t  next_state;
  iclass_t iclass;
  logic    dec_illegal;

  mc_ctrl_decode u_decode (
    .op      (op),
    .funct   (funct),
    .iclass  (iclass),
    .illegal (dec_illegal)
  );

  assign state_o = ST_W'(state);

  // State register; async reset aborts any instruction in flight and all strobes drop with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode; every output defaults to 0 so unlisted states drive nothing.
  always_comb begin
    next_state  = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = PC_ALU;
    reg_write   = 1'b0;
    reg_dst_sel = DST_RT;
    wd_sel      = WD_ALUOUT;
    alu_a_sel   = A_PC;
    alu_b_sel   = B_GPR;
    alu_ctrl    = ALU_ADD;
    illegal     = 1'b0;

    case (state)
      ST_INIT: next_state = ST_FETCH;

      ST_FETCH: begin
        // PC+4 is computed every fetch cycle but only committed with the IR load.
        mem_req   = 1'b1;
        alu_b_sel = B_FOUR;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
        if (mem_ack) next_state = ST_DECODE;
      end

      ST_DECODE: begin
        // Branch target PC+sext(imm) is precomputed here for BR.
        alu_b_sel = B_SEXT;
        case (iclass)
          CL_ADDU, CL_SUBU:      next_state = ST_EXEC_R;
          CL_ORI, CL_LUI:        next_state = ST_EXEC_I;
          CL_LW, CL_SW:          next_state = ST_MADDR;
          CL_BEQ:                next_state = ST_BR;
          CL_J, CL_JAL, CL_JR:   next_state = ST_JMP;
          default: begin
            illegal    = dec_illegal;
            next_state = ST_FETCH;
          end
        endcase
      end

      ST_EXEC_R: begin
        alu_a_sel  = A_GPR;
        alu_b_sel  = B_GPR;
        alu_ctrl   = (iclass == CL_SUBU) ? ALU_SUB : ALU_ADD;
        next_state = ST_WB_R;
      end

      ST_WB_R: begin
        reg_write   = 1'b1;
        reg_dst_sel = DST_RD;
        wd_sel      = WD_ALUOUT;
        next_state  = ST_FETCH;
      end

      ST_EXEC_I: begin
        // lui needs no ALU work; its result comes straight from imm<<16 in WB_I.
        if (iclass == CL_ORI) begin
          alu_a_sel = A_GPR;
          alu_b_sel = B_ZEXT;
          alu_ctrl  = ALU_OR;
        end
        next_state = ST_WB_I;
      end

      ST_WB_I: begin
        reg_write   = 1'b1;
        reg_dst_sel = DST_RT;
        wd_sel      = (iclass == CL_LUI) ? WD_LUI : WD_ALUOUT;
        next_state  = ST_FETCH;
      end

      ST_MADDR: begin
        alu_a_sel  = A_GPR;
        alu_b_sel  = B_SEXT;
        alu_ctrl   = ALU_ADD;
        next_state = (iclass == CL_LW) ? ST_MRD : ST_MWR;
      end

      ST_MRD: begin
        mem_req = 1'b1;
        if (mem_ack) next_state = ST_MWB;
      end

      ST_MWB: begin
        reg_write   = 1'b1;
        reg_dst_sel = DST_RT;
        wd_sel      = WD_MDR;
        next_state  = ST_FETCH;
      end

      ST_MWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) next_state = ST_FETCH;
      end

      ST_BR: begin
        alu_a_sel  = A_GPR;
        alu_b_sel  = B_GPR;
        alu_ctrl   = ALU_SUB;
        pc_sel     = PC_BRANCH;
        pc_write   = zero;
        next_state = ST_FETCH;
      end

      ST_JMP: begin
        pc_write = 1'b1;
        pc_sel   = (iclass == CL_JR) ? PC_GPR : PC_JUMP;
        if (iclass == CL_JAL) begin
          reg_write   = 1'b1;
          reg_dst_sel = DST_RA;
          wd_sel      = WD_PC;
        end
        next_state = ST_FETCH;
      end

      default: next_state = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - scoreboard bench for mc_ctrl_fsm with a per-instruction cycle-trace model
module tb_mc_ctrl_fsm;

  localparam int ST_W = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [5:0]      op;
  logic [5:0]      funct;
  logic            zero;
  logic            mem_ack;
  logic            mem_req;
  logic            mem_we;
  logic            ir_write;
  logic            pc_write;
  logic [1:0]      pc_sel;
  logic            reg_write;
  logic [1:0]      reg_dst_sel;
  logic [1:0]      wd_sel;
  logic            alu_a_sel;
  logic [1:0]      alu_b_sel;
  logic [1:0]      alu_ctrl;
  logic            illegal;
  logic [ST_W-1:0] state_o;

  mc_ctrl_fsm #(.ST_W(ST_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .reg_write   (reg_write),
    .reg_dst_sel (reg_dst_sel),
    .wd_sel      (wd_sel),
    .alu_a_sel   (alu_a_sel),
    .alu_b_sel   (alu_b_sel),
    .alu_ctrl    (alu_ctrl),
    .illegal     (illegal),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // One observed cycle of the control outputs
  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       reg_write;
    logic [1:0] reg_dst_sel;
    logic [1:0] wd_sel;
    logic       alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] alu_ctrl;
    logic       illegal;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  obs_t  act;
  obs_t  mon_e;
  string mon_t;
  logic [5:0] cur_op    = 6'd0;
  logic [5:0] cur_funct = 6'd0;

  assign act = {state_o[3:0], mem_req, mem_we, ir_write, pc_write, pc_sel, reg_write,
                reg_dst_sel, wd_sel, alu_a_sel, alu_b_sel, alu_ctrl, illegal};

  // Monitor: every sampled cycle consumes one expected entry
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      checks++;
      if (act !== mon_e) begin
        errors++;
        $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                 mon_t, act, act.st, mon_e, mon_e.st);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t blank(input int st);
    obs_t e;
    e = '0;
    e.st = 4'(st);
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction set as a lookup from IR fields to mnemonic
  function automatic string classify(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      if (f == 6'h21) return "addu";
      if (f == 6'h23) return "subu";
      if (f == 6'h08) return "jr";
      return "ill";
    end
    case (o)
      6'h0d: return "ori";
      6'h0f: return "lui";
      6'h23: return "lw";
      6'h2b: return "sw";
      6'h04: return "beq";
      6'h02: return "j";
      6'h03: return "jal";
      default: return "ill";
    endcase
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue its expected outputs
  task automatic step(input obs_t e, input logic ack, input logic z, input string t);
    @(posedge clk);
    #1;
    op      = cur_op;
    funct   = cur_funct;
    mem_ack = ack;
    zero    = z;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic do_fetch(input int waits, input string nm);
    obs_t e;
    logic ack;
    for (int w = 0; w <= waits; w++) begin
      ack = (w == waits);
      e = blank(1);
      e.mem_req   = 1'b1;
      e.alu_b_sel = 2'b01;
      e.ir_write  = ack;
      e.pc_write  = ack;
      step(e, ack, rbit(), {nm, "/FETCH"});
    end
  endtask

  // Reference trace for one instruction from FETCH through its last state
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw,
                           input int mw, input logic z);
    string nm;
    obs_t  e;
    nm = classify(o, f);
    cur_op    = o;
    cur_funct = f;
    do_fetch(fw, nm);

    e = blank(2);
    e.alu_b_sel = 2'b10;
    if (nm == "ill") e.illegal = 1'b1;
    step(e, rbit(), rbit(), {nm, "/DECODE"});
    if (nm == "ill") return;

    if (nm == "addu" || nm == "subu") begin
      e = blank(3);
      e.alu_a_sel = 1'b1;
      e.alu_ctrl  = (nm == "subu") ? 2'b01 : 2'b00;
      step(e, rbit(), rbit(), {nm, "/EXEC_R"});
      e = blank(4);
      e.reg_write   = 1'b1;
      e.reg_dst_sel = 2'b01;
      step(e, rbit(), rbit(), {nm, "/WB_R"});
    end else if (nm == "ori" || nm == "lui") begin
      e = blank(5);
      if (nm == "ori") begin
        e.alu_a_sel = 1'b1;
        e.alu_b_sel = 2'b11;
        e.alu_ctrl  = 2'b10;
      end
      step(e, rbit(), rbit(), {nm, "/EXEC_I"});
      e = blank(6);
      e.reg_write = 1'b1;
      e.wd_sel    = (nm == "lui") ? 2'b11 : 2'b00;
      step(e, rbit(), rbit(), {nm, "/WB_I"});
    end else if (nm == "lw" || nm == "sw") begin
      e = blank(7);
      e.alu_a_sel = 1'b1;
      e.alu_b_sel = 2'b10;
      step(e, rbit(), rbit(), {nm, "/MADDR"});
      for (int w = 0; w <= mw; w++) begin
        e = blank((nm == "lw") ? 8 : 10);
        e.mem_req = 1'b1;
        e.mem_we  = (nm == "sw");
        step(e, (w == mw), rbit(), {nm, "/MEM"});
      end
      if (nm == "lw") begin
        e = blank(9);
        e.reg_write = 1'b1;
        e.wd_sel    = 2'b01;
        step(e, rbit(), rbit(), {nm, "/MWB"});
      end
    end else if (nm == "beq") begin
      e = blank(11);
      e.alu_a_sel = 1'b1;
      e.alu_ctrl  = 2'b01;
      e.pc_sel    = 2'b01;
      e.pc_write  = z;
      step(e, rbit(), z, {nm, "/BR"});
    end else begin
      e = blank(12);
      e.pc_write = 1'b1;
      e.pc_sel   = (nm == "jr") ? 2'b11 : 2'b10;
      if (nm == "jal") begin
        e.reg_write   = 1'b1;
        e.reg_dst_sel = 2'b10;
        e.wd_sel      = 2'b10;
      end
      step(e, rbit(), rbit(), {nm, "/JMP"});
    end
  endtask

  task automatic reset_release(input string t);
    step(blank(0), 1'b0, 1'b0, {t, "/INIT"});
    reset_n = 1'b1;
  endtask

  logic [5:0] legal_ops [10] = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
  logic [5:0] legal_fns [10] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    obs_t e;
    int   k;
    logic [5:0] ro;
    logic [5:0] rf;
    reset_n = 1'b0;
    op      = 6'd0;
    funct   = 6'd0;
    zero    = 1'b0;
    mem_ack = 1'b0;

    // Reset held for three cycles, then one INIT cycle
    for (int i = 0; i < 3; i++) step(blank(0), rbit(), rbit(), "reset");
    reset_release("reset");

    // Directed cases
    run_instr(6'h00, 6'h21, 0, 0, 1'b0);   // addu
    run_instr(6'h00, 6'h23, 0, 0, 1'b0);   // subu
    run_instr(6'h23, 6'h00, 0, 2, 1'b0);   // lw, two wait cycles in MRD
    run_instr(6'h04, 6'h00, 0, 0, 1'b0);   // beq not taken
    run_instr(6'h04, 6'h00, 0, 0, 1'b1);   // beq taken
    run_instr(6'h03, 6'h00, 0, 0, 1'b0);   // jal
    run_instr(6'h00, 6'h08, 0, 0, 1'b0);   // jr
    run_instr(6'h3f, 6'h00, 0, 0, 1'b0);   // illegal opcode
    run_instr(6'h0d, 6'h15, 1, 0, 1'b0);   // ori with a fetch wait
    run_instr(6'h0f, 6'h00, 0, 0, 1'b0);   // lui
    run_instr(6'h2b, 6'h00, 0, 1, 1'b0);   // sw
    run_instr(6'h02, 6'h00, 2, 0, 1'b0);   // j

    // sw aborted by asynchronous reset while waiting in MWR
    cur_op    = 6'h2b;
    cur_funct = 6'h00;
    do_fetch(0, "sw_abort");
    e = blank(2);
    e.alu_b_sel = 2'b10;
    step(e, 1'b0, 1'b0, "sw_abort/DECODE");
    e = blank(7);
    e.alu_a_sel = 1'b1;
    e.alu_b_sel = 2'b10;
    step(e, 1'b0, 1'b0, "sw_abort/MADDR");
    e = blank(10);
    e.mem_req = 1'b1;
    e.mem_we  = 1'b1;
    step(e, 1'b0, 1'b0, "sw_abort/MWR");
    step(blank(0), 1'b0, 1'b0, "sw_abort/async_reset");
    #2;
    reset_n = 1'b0;
    step(blank(0), 1'b1, 1'b0, "sw_abort/in_reset");
    reset_release("sw_abort");
    run_instr(6'h00, 6'h21, 0, 0, 1'b0);   // resumes normally after abort

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 11);
      if (k < 10) begin
        ro = legal_ops[k];
        rf = (ro == 6'h00) ? legal_fns[k] : 6'($urandom);
      end else begin
        ro = 6'($urandom);
        rf = 6'($urandom);
      end
      run_instr(ro, rf, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
